// File: rtl/chimera_clu_iso_ctrl.sv
// Per-cluster isolation/power sequencer: isolate, await ack, hold reset, gate clock; reverse on power-on.
// Moore outputs are registered from the next state, so they change on the edge the state changes.
module chimera_clu_iso_ctrl #(
  parameter int unsigned NumClusters   = 4,
  parameter int unsigned ResetCycles   = 8,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] off_req_i,
  input  logic [NumClusters-1:0] isolated_i,
  input  logic [NumClusters-1:0] err_clr_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] is_off_o,
  output logic [NumClusters-1:0] err_o
);

  localparam int unsigned MaxRs  = (ResetCycles > SettleCycles) ? ResetCycles : SettleCycles;
  localparam int unsigned MaxAll = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
  localparam int unsigned CntMax = (MaxAll > 2) ? MaxAll : 2;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t RstLast = cnt_t'(ResetCycles - 1);
  localparam cnt_t SetLast = cnt_t'(SettleCycles - 1);
  localparam cnt_t ToLast  = cnt_t'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam bit   ToEn    = (TimeoutCycles != 0);

  typedef enum logic [2:0] {
    StOn, StIsoWait, StRstOn, StGate, StOff, StUngate, StRelease, StDeiso
  } state_e;

  for (genvar g = 0; g < NumClusters; g++) begin : gen_clu
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   err_q, err_d;
    logic   iso_q, iso_d, clk_en_q, clk_en_d, rst_n_q, rst_n_d;
    logic   busy_q, busy_d, off_q, off_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q & ~err_clr_i[g];
      unique case (state_q)
        StOn: if (off_req_i[g]) begin
          state_d = StIsoWait;
          cnt_d   = '0;
        end
        StIsoWait: begin
          if (isolated_i[g]) begin
            state_d = StRstOn;
            cnt_d   = '0;
          end else if (ToEn && cnt_q == ToLast) begin
            // Abort the power-off: the cluster never acked, so it stays clocked and out of reset.
            err_d   = 1'b1;
            state_d = StOn;
            cnt_d   = '0;
          end else if (ToEn) begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StRstOn: begin
          if (cnt_q == RstLast) state_d = StGate;
          else                  cnt_d   = cnt_q + cnt_t'(1);
        end
        StGate: state_d = StOff;
        StOff: if (!off_req_i[g]) begin
          state_d = StUngate;
          cnt_d   = '0;
        end
        StUngate: begin
          if (cnt_q == RstLast) begin
            state_d = StRelease;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StRelease: begin
          if (cnt_q == SetLast) begin
            state_d = StDeiso;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StDeiso: begin
          if (!isolated_i[g]) begin
            state_d = StOn;
            cnt_d   = '0;
          end else if (ToEn && cnt_q == ToLast) begin
            err_d   = 1'b1;
            state_d = StOn;
            cnt_d   = '0;
          end else if (ToEn) begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_d = StOn;
          cnt_d   = '0;
        end
      endcase

      iso_d    = !(state_d inside {StOn, StDeiso});
      clk_en_d = !(state_d inside {StGate, StOff});
      rst_n_d  = state_d inside {StOn, StIsoWait, StRelease, StDeiso};
      busy_d   = !(state_d inside {StOn, StOff});
      off_d    = (state_d == StOff);
    end

    always_ff @(posedge soc_clk_i) begin
      if (!rst_ni) begin
        state_q  <= StOn;
        cnt_q    <= '0;
        err_q    <= 1'b0;
        iso_q    <= 1'b0;
        clk_en_q <= 1'b1;
        rst_n_q  <= 1'b1;
        busy_q   <= 1'b0;
        off_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        err_q    <= err_d;
        iso_q    <= iso_d;
        clk_en_q <= clk_en_d;
        rst_n_q  <= rst_n_d;
        busy_q   <= busy_d;
        off_q    <= off_d;
      end
    end

    assign isolate_o[g]  = iso_q;
    assign clk_en_o[g]   = clk_en_q;
    assign clu_rst_no[g] = rst_n_q;
    assign busy_o[g]     = busy_q;
    assign is_off_o[g]   = off_q;
    assign err_o[g]      = err_q;
  end

endmodule

// File: tb/tb_chimera_clu_iso_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a phase/countdown model.
module tb_chimera_clu_iso_ctrl;
  localparam int NC = 4;
  localparam int R  = 8;
  localparam int S  = 4;
  localparam int T  = 16;

  localparam int P_ON = 0, P_ISOW = 1, P_RST = 2, P_GATE = 3;
  localparam int P_OFF = 4, P_UNG = 5, P_REL = 6, P_DEISO = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] off_req, iso_in, err_clr;
  logic [NC-1:0] isolate_o, clk_en_o, clu_rst_no, busy_o, is_off_o, err_o;

  int checks = 0;
  int errors = 0;

  int ph[NC];
  int left[NC];
  int waited[NC];
  bit merr[NC];

  bit iso_tab[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit clk_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  bit rst_tab[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  chimera_clu_iso_ctrl #(
    .NumClusters(NC), .ResetCycles(R), .SettleCycles(S), .TimeoutCycles(T)
  ) dut (
    .soc_clk_i (clk),
    .rst_ni    (rst_n),
    .off_req_i (off_req),
    .isolated_i(iso_in),
    .err_clr_i (err_clr),
    .isolate_o (isolate_o),
    .clk_en_o  (clk_en_o),
    .clu_rst_no(clu_rst_no),
    .busy_o    (busy_o),
    .is_off_o  (is_off_o),
    .err_o     (err_o)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Timed phases count down from their length; wait phases count up toward the timeout.
  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit set_err;
      set_err = 1'b0;
      if (!rst_n) begin
        ph[c] = P_ON; left[c] = 0; waited[c] = 0; merr[c] = 1'b0;
      end else begin
        case (ph[c])
          P_ON:   if (off_req[c]) begin ph[c] = P_ISOW; waited[c] = 0; end
          P_ISOW: begin
            if (iso_in[c]) begin ph[c] = P_RST; left[c] = R; end
            else begin
              waited[c]++;
              if (T != 0 && waited[c] == T) begin set_err = 1'b1; ph[c] = P_ON; end
            end
          end
          P_RST:  begin left[c]--; if (left[c] == 0) ph[c] = P_GATE; end
          P_GATE: ph[c] = P_OFF;
          P_OFF:  if (!off_req[c]) begin ph[c] = P_UNG; left[c] = R; end
          P_UNG:  begin left[c]--; if (left[c] == 0) begin ph[c] = P_REL; left[c] = S; end end
          P_REL:  begin left[c]--; if (left[c] == 0) begin ph[c] = P_DEISO; waited[c] = 0; end end
          default: begin
            if (!iso_in[c]) ph[c] = P_ON;
            else begin
              waited[c]++;
              if (T != 0 && waited[c] == T) begin set_err = 1'b1; ph[c] = P_ON; end
            end
          end
        endcase
        merr[c] = set_err | (merr[c] & ~err_clr[c]);
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("isolate[%0d]", c), isolate_o[c], iso_tab[ph[c]]);
      chk($sformatf("clk_en[%0d]", c), clk_en_o[c], clk_tab[ph[c]]);
      chk($sformatf("clu_rst_n[%0d]", c), clu_rst_no[c], rst_tab[ph[c]]);
      chk($sformatf("busy[%0d]", c), busy_o[c], (ph[c] != P_ON && ph[c] != P_OFF));
      chk($sformatf("is_off[%0d]", c), is_off_o[c], (ph[c] == P_OFF));
      chk($sformatf("err[%0d]", c), err_o[c], merr[c]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int gate_k, off_k, drop_k, on_k;
    int d[NC];
    int offk[NC];
    bit stuck[NC];

    rst_n = 1'b0; off_req = '0; iso_in = '0; err_clr = '0;
    tick(); tick();
    chk("reset_clk_en0", clk_en_o[0], 1'b1);
    chk("reset_rst_n0", clu_rst_no[0], 1'b1);
    chk("reset_iso0", isolate_o[0], 1'b0);
    rst_n = 1'b1;
    tick();

    // T1: ack arrives 3 cycles after isolate rises
    off_req[0] = 1'b1; gate_k = -1; off_k = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1 + 3) iso_in[0] = 1'b1;
      if (gate_k < 0 && clk_en_o[0] == 1'b0) gate_k = k;
      if (off_k < 0 && is_off_o[0] == 1'b1) off_k = k;
    end
    chk_int("t1_gate_cycle", gate_k, 1 + 3 + R + 1);
    chk_int("t1_off_cycle", off_k, 1 + 3 + R + 2);

    // T2: power back on, cluster drops its ack once isolate falls
    off_req[0] = 1'b0; drop_k = -1; on_k = -1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (isolate_o[0] == 1'b0) iso_in[0] = 1'b0;
      if (drop_k < 0 && isolate_o[0] == 1'b0) drop_k = k;
      if (on_k < 0 && busy_o[0] == 1'b0) on_k = k;
    end
    chk_int("t2_deiso_cycle", drop_k, R + S + 1);
    chk_int("t2_on_cycle", on_k, R + S + 2);

    // T3: no ack -> timeout; clear pulse coinciding with the timeout loses to the set
    off_req[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) begin
        chk("t3_iso_before_to", isolate_o[1], 1'b1);
        chk("t3_err_before_to", err_o[1], 1'b0);
        err_clr[1] = 1'b1;
      end
    end
    chk("t3_err_set_wins", err_o[1], 1'b1);
    chk("t3_iso_dropped", isolate_o[1], 1'b0);
    chk("t3_clk_en", clk_en_o[1], 1'b1);
    chk("t3_rst_n", clu_rst_no[1], 1'b1);
    off_req[1] = 1'b0; err_clr[1] = 1'b0;
    tick();
    chk("t3_err_sticky", err_o[1], 1'b1);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("t3_err_cleared", err_o[1], 1'b0);

    // T4: off request withdrawn during reset hold
    off_req[2] = 1'b1; iso_in[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) off_req[2] = 1'b0;
      if (k == 2 + R + 1) chk("t4_reached_off", is_off_o[2], 1'b1);
      if (k == 2 + R + 2) begin
        chk("t4_ungate_clk", clk_en_o[2], 1'b1);
        chk("t4_ungate_rst", clu_rst_no[2], 1'b0);
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      iso_in[2] = isolate_o[2];
    end
    chk("t4_back_on", busy_o[2], 1'b0);

    // T5: reset asserted while gating
    off_req[3] = 1'b1; iso_in[3] = 1'b1;
    for (int k = 1; k <= 2 + R; k++) tick();
    chk("t5_in_gate", clk_en_o[3], 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_clk_en", clk_en_o[3], 1'b1);
    chk("t5_rst_n", clu_rst_no[3], 1'b1);
    chk("t5_iso", isolate_o[3], 1'b0);
    rst_n = 1'b1; off_req = '0; iso_in = '0;
    tick();

    // T6: all clusters at once with different ack delays
    d = '{0, 2, 5, 9};
    off_req = '1;
    for (int c = 0; c < NC; c++) offk[c] = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (k == 1 + d[c]) iso_in[c] = 1'b1;
        if (offk[c] < 0 && is_off_o[c] == 1'b1) offk[c] = k;
      end
    end
    for (int c = 0; c < NC; c++) chk_int($sformatf("t6_off_cycle[%0d]", c), offk[c], 2 + d[c] + R + 1);
    off_req = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      iso_in = isolate_o;
    end

    // Randomized traffic; a stuck cluster ignores isolate to provoke timeouts
    for (int c = 0; c < NC; c++) stuck[c] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 19) == 0) off_req[c] = ~off_req[c];
        if ($urandom_range(0, 99) == 0) stuck[c] = ~stuck[c];
        if (!stuck[c] && $urandom_range(0, 3) != 0) iso_in[c] = isolate_o[c];
        err_clr[c] = ($urandom_range(0, 15) == 0);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
